// File: rtl/filtro_pkg.sv
// Shared constants, width helpers and saturation for the window convolution filter.
// Optional build macro used by the filter: VALOR_ABSOLUTO_EN.
package filtro_pkg;

    localparam int NUM_PIXELES_VENTANA = 25;
    localparam int INDICE_CENTRO       = 12;
    localparam int LADO_VENTANA        = 5;

    // Zero-based coefficient indices of the centred 3x3 sub-window (pixels 7..9, 12..14, 17..19).
    localparam int INDICES_3X3 [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

    function automatic int ancho_producto(input int bits_pixel, input int bits_coef);
        return bits_pixel + bits_coef + 1;
    endfunction

    function automatic int ancho_suma_fila(input int bits_pixel, input int bits_coef);
        return ancho_producto(bits_pixel, bits_coef) + 3;
    endfunction

    function automatic int ancho_total(input int bits_pixel, input int bits_coef);
        return ancho_producto(bits_pixel, bits_coef) + 5;
    endfunction

    localparam int ANCHO_PRODUCTO_DEF = ancho_producto(8, 8);
    localparam int ANCHO_FILA_DEF     = ancho_suma_fila(8, 8);

    function automatic logic [NUM_PIXELES_VENTANA-1:0] mascara_3x3();
        logic [NUM_PIXELES_VENTANA-1:0] m;
        m = '0;
        for (int i = 0; i < 9; i++) m[INDICES_3X3[i]] = 1'b1;
        return m;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^bits-1].
    function automatic logic [63:0] saturar(input logic signed [63:0] v, input int bits);
        logic [63:0] maximo;
        maximo = (64'd1 << bits) - 64'd1;
        if (v < 0) return '0;
        if ($unsigned(v) > maximo) return maximo;
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/suma_fila_5.sv
// Registered signed sum of the five products of one window row.
module suma_fila_5
    import filtro_pkg::*;
#(
    parameter int W_PROD = ANCHO_PRODUCTO_DEF,
    parameter int W_SUMA = ANCHO_FILA_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic [LADO_VENTANA-1:0][W_PROD-1:0]  productos,
    output logic signed [W_SUMA-1:0]             suma
);

    logic signed [W_SUMA-1:0] acumulado;

    always_comb begin
        acumulado = '0;
        for (int i = 0; i < LADO_VENTANA; i++)
            acumulado = acumulado + W_SUMA'($signed(productos[i]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  suma <= '0;
        else if (en) suma <= acumulado;
    end

endmodule

// File: rtl/filtro_convolucion_ventana.sv
// 3-stage 5x5/3x3 convolution over a pixel window with loadable coefficients.
// Build option VALOR_ABSOLUTO_EN: negative shifted totals are replaced by their magnitude.
module filtro_convolucion_ventana
    import filtro_pkg::*;
#(
    parameter int BITS_PIXEL   = 8,
    parameter int BITS_COEF    = 8,
    parameter int BITS_MASCARA = 3,
    parameter int BITS_DESPLAZ = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [BITS_MASCARA-1:0]                   tamano_mascara,
    input  logic [NUM_PIXELES_VENTANA*BITS_PIXEL-1:0] ventana,
    input  logic                                      ventana_valida,
    output logic                                      siguiente_ventana,
    input  logic                                      cargar_coef,
    input  logic [4:0]                                indice_coef,
    input  logic [BITS_COEF-1:0]                      coef_entrada,
    input  logic                                      cargar_desplaz,
    input  logic [BITS_DESPLAZ-1:0]                   desplaz_entrada,
    output logic [BITS_PIXEL-1:0]                     pixel_salida,
    output logic                                      pixel_valido,
    input  logic                                      salida_lista
);

    localparam int W_PROD  = ancho_producto(BITS_PIXEL, BITS_COEF);
    localparam int W_FILA  = ancho_suma_fila(BITS_PIXEL, BITS_COEF);
    localparam int W_TOTAL = ancho_total(BITS_PIXEL, BITS_COEF);
    localparam int STAGES  = 3;
    localparam logic [NUM_PIXELES_VENTANA-1:0] MASCARA_3X3 = mascara_3x3();

    logic               avanzar;
    logic [STAGES:1]    vld_pipe;

    // The whole pipeline freezes only when a finished pixel is waiting on downstream.
    assign avanzar           = !(pixel_valido && !salida_lista);
    assign siguiente_ventana = ventana_valida && avanzar && reset;
    assign pixel_valido      = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       vld_pipe <= '0;
        else if (avanzar) vld_pipe <= {vld_pipe[STAGES-1:1], ventana_valida};
    end

    // Coefficient and shift registers.
    logic signed [BITS_COEF-1:0] coef [NUM_PIXELES_VENTANA];
    logic [BITS_DESPLAZ-1:0]     desplaz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_PIXELES_VENTANA; k++)
                coef[k] <= (k == INDICE_CENTRO) ? BITS_COEF'(1) : '0;
        end else if (cargar_coef && (indice_coef < 5'(NUM_PIXELES_VENTANA))) begin
            coef[indice_coef] <= coef_entrada;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              desplaz <= '0;
        else if (cargar_desplaz) desplaz <= desplaz_entrada;
    end

    // Stage 1: products, with outer ring zeroed in 3x3 mode.
    logic                                          modo_5x5;
    logic [NUM_PIXELES_VENTANA-1:0][W_PROD-1:0]    prod_d;
    logic [NUM_PIXELES_VENTANA-1:0][W_PROD-1:0]    prod_q;
    logic [BITS_DESPLAZ-1:0]                       desp1;

    assign modo_5x5 = (tamano_mascara == BITS_MASCARA'(5));

    always_comb begin
        prod_d = '0;
        for (int k = 0; k < NUM_PIXELES_VENTANA; k++) begin
            if (modo_5x5 || MASCARA_3X3[k])
                prod_d[k] = W_PROD'($signed({1'b0, ventana[k*BITS_PIXEL +: BITS_PIXEL]}))
                          * W_PROD'(coef[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            desp1  <= '0;
        end else if (avanzar) begin
            prod_q <= prod_d;
            desp1  <= desplaz;
        end
    end

    // Stage 2: five registered row sums.
    logic [LADO_VENTANA-1:0][W_FILA-1:0] fila_q;
    logic [BITS_DESPLAZ-1:0]             desp2;

    genvar r;
    generate
        for (r = 0; r < LADO_VENTANA; r++) begin : g_fila
            suma_fila_5 #(
                .W_PROD (W_PROD),
                .W_SUMA (W_FILA)
            ) u_fila (
                .clk       (clk),
                .reset     (reset),
                .en        (avanzar),
                .productos (prod_q[r*LADO_VENTANA +: LADO_VENTANA]),
                .suma      (fila_q[r])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       desp2 <= '0;
        else if (avanzar) desp2 <= desp1;
    end

    // Stage 3: total, normalise, saturate.
    logic signed [W_TOTAL-1:0] total;
    logic signed [W_TOTAL-1:0] desplazado;
    logic [BITS_PIXEL-1:0]     pixel_sat;

    always_comb begin
        total = '0;
        for (int i = 0; i < LADO_VENTANA; i++)
            total = total + W_TOTAL'($signed(fila_q[i]));
        desplazado = total >>> desp2;
`ifdef VALOR_ABSOLUTO_EN
        if (desplazado < 0) desplazado = -desplazado;
`endif
        pixel_sat = BITS_PIXEL'(saturar(64'(desplazado), BITS_PIXEL));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           pixel_salida <= '0;
        else if (avanzar && vld_pipe[STAGES-1]) pixel_salida <= pixel_sat;
    end

endmodule
